// File: rtl/if_fetch.sv
// Instruction-fetch stage: one-outstanding request/ack read of instruction memory,
// a small {pc, inst} FIFO, and the registered IF/ID outputs with flush/stall control.
module if_fetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        ce,
    input  logic [5:0]  stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        fetch_stall_req,
    output logic [1:0]  dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t        state, state_next;
    logic          issue, push, pop;
    logic [31:0]   req_pc;
    logic [31:0]   fifo_pc   [DEPTH];
    logic [31:0]   fifo_inst [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          unused_stall;

    assign unused_stall = ^{stall[5:2], stall[0]};

    // Handshake: imem_req rises on the issue edge and stays high, with imem_addr
    // stable, until the edge that samples imem_ack=1; an ack outside WAIT/DROP is ignored.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst && ce && (count < DEPTH_CNT) && !flush) begin
                    issue      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    push       = !flush;
                    state_next = S_IDLE;
                end else if (flush) begin
                    state_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign pop             = !flush && !stall[1] && (count != '0);
    assign fetch_stall_req = !issue;
    assign dbg_state       = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
            req_pc    <= 32'h0;
        end else begin
            state <= state_next;
            if (issue) begin
                imem_req  <= 1'b1;
                imem_addr <= pc;
                req_pc    <= pc;
            end else if (state != S_IDLE && imem_ack) begin
                imem_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= req_pc;
            fifo_inst[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (!push && pop) count <= count - CNT_ONE;
        end
    end

    // Pop reads the head before any same-cycle push, so an empty FIFO never bypasses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            id_pc    <= 32'h0;
            id_inst  <= 32'h0;
            id_valid <= 1'b0;
        end else if (flush) begin
            id_inst  <= 32'h0;
            id_valid <= 1'b0;
        end else if (!stall[1]) begin
            if (count != '0) begin
                id_pc    <= fifo_pc[rd_ptr];
                id_inst  <= fifo_inst[rd_ptr];
                id_valid <= 1'b1;
            end else begin
                id_inst  <= 32'h0;
                id_valid <= 1'b0;
            end
        end
    end

endmodule
